// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit feeding a 2-entry result queue with valid/ready handshakes.
// Optional per-entry all-zero flag and the zero port are built when LOGIC_UNIT_FLAGS_EN is defined.
module logic_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic             zero
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ANDN, OP_NAND, OP_XNOR, OP_PASS
  } op_t;

  state_t           state, state_nxt;
  logic             ready_q;
  logic             push, pop;
  logic             wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [2];
  logic [WIDTH-1:0] calc;

  // Ready and valid depend only on registered state, so out_ready never reaches in_ready.
  assign in_ready  = ready_q && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    calc = '0;
    case (op_t'(op))
      OP_AND:  calc = a & b;
      OP_OR:   calc = a | b;
      OP_XOR:  calc = a ^ b;
      OP_NOR:  calc = ~(a | b);
      OP_ANDN: calc = a & ~b;
      OP_NAND: calc = ~(a & b);
      OP_XNOR: calc = ~(a ^ b);
      OP_PASS: calc = a;
      default: calc = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= 1'b1;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // NOTE: the two entries are reset because the head entry drives result directly and must read 0 in reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= calc;
    end
  end

  assign result = mem[rd_ptr];

`ifdef LOGIC_UNIT_FLAGS_EN
  logic zflag [2];

  // Flags reset to 1 to match the all-zero reset contents of the entries.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      zflag[0] <= 1'b1;
      zflag[1] <= 1'b1;
    end else if (push) begin
      zflag[wr_ptr] <= (calc == '0);
    end
  end

  assign zero = zflag[rd_ptr];
`endif

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 1..64).
REQ-002 SHALL have port clock, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, operand set presented.
REQ-005 SHALL have port in_ready, output, 1, block accepts an operand set this cycle.
REQ-006 SHALL have port op, input, 3, operation select.
REQ-007 SHALL have ports a and b, input, WIDTH each, operands.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-010 SHALL have port result, output, WIDTH, head-of-queue result.
REQ-011 SHALL have port zero, output, 1, head result is all-zero (present only with LOGIC_UNIT_FLAGS_EN).

Function
REQ-012 SHALL compute bitwise per op: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ANDN (a & ~b), 101 NAND, 110 XNOR, 111 PASS (a).
REQ-013 SHALL accept an operand set on a rising edge where in_valid && in_ready (push).
REQ-014 SHALL deliver a result on a rising edge where out_valid && out_ready (pop).
REQ-015 SHALL store computed results in a 2-entry queue; count in {0,1,2}; states EMPTY, ONE, FULL.
REQ-016 SHALL drive in_ready = (count != 2), registered-state derived, with no combinational path from out_ready.
REQ-017 SHALL drive out_valid = (count != 0); result and zero SHALL come only from registers.
REQ-018 SHALL present a result pushed at edge k on result with out_valid high in the cycle after edge k (latency 1).
REQ-019 Transitions: EMPTY --push--> ONE; ONE --push only--> FULL; ONE --pop only--> EMPTY; ONE --push and pop--> ONE; FULL --pop--> ONE; all other cases hold.
REQ-020 SHALL preserve push order in delivery (FIFO); read/write pointers wrap modulo 2.
REQ-021 SHALL hold result, zero and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL ignore a, b, op when no push occurs; in_valid while FULL is not accepted and is not lost by the producer's handshake.
REQ-023 SHALL not sustain a push and a pop in the same cycle in FULL (in_ready low).

Reset
REQ-024 SHALL, while reset_n is low, force count to 0, pointers to 0, stored entries to 0, out_valid to 0, result to 0, zero to 1, in_ready to 0.
REQ-025 SHALL, after reset_n rises, drive in_ready high from the first clock edge onward.
REQ-026 SHALL discard queued results when reset asserts mid-operation; no result is delivered after reset release without a new push.

Configuration
REQ-027 With macro LOGIC_UNIT_FLAGS_EN defined, SHALL store a zero flag per entry and drive port zero = (head result == 0), valid when out_valid.
REQ-028 Without LOGIC_UNIT_FLAGS_EN, port zero and its storage SHALL be absent; all other behaviour identical.

Verification (WIDTH=32)
REQ-029 Push a=0xF0F0_1234, b=0xFF00_FFFF, op=000, out_ready=1 -> next cycle out_valid=1, result=0xF000_1234, zero=0.
REQ-030 Three back-to-back pushes (op=001,010,100 on a=0x0000_00FF, b=0x0000_0F0F) with out_ready=0 -> in_ready low after 2nd push, 3rd held; then out_ready=1 -> results 0x0000_0FFF, 0x0000_0FF0 in order, 3rd accepted and then yields 0x0000_00F0.
REQ-031 Steady stream, in_valid=1, out_ready=1, count=1 -> one result per cycle, count stays 1, in_ready stays 1.
REQ-032 Push a=0x1234_5678, b=0x1234_5678, op=010 -> result=0x0000_0000, zero=1 (flags build); op=111 -> result=0x1234_5678.
REQ-033 Fill to FULL, assert reset_n=0 mid-cycle -> out_valid and in_ready drop immediately, result=0; after release, out_valid stays 0 until a new push.
